// File: rtl/layered_color_mapper.sv
// Per-pixel colour compositor: picks the top visible layer (sprites, food, wall, background),
// then applies ghost fright/flash colouring. Two register stages, one pixel per cycle.
module layered_color_mapper #(
  parameter int          NUM_SPRITES  = 4,
  parameter logic [23:0] KEY_RGB      = 24'h000000,
  parameter int unsigned MAZE_Y_MAX   = 352,
  parameter int unsigned BLINK_FRAMES = 16,
  parameter logic [23:0] WALL_RGB     = 24'hFF0000,
  parameter logic [23:0] FOOD_RGB     = 24'hFFFF00,
  parameter logic [23:0] BG_RGB       = 24'h3F007F,
  parameter logic [23:0] FRIGHT_RGB   = 24'h2121FF,
  parameter logic [23:0] FLASH_RGB    = 24'hFFFFFF
) (
  input  logic                        Clk,
  input  logic                        Reset,
  input  logic                        pixel_valid,
  input  logic                        frame_start,
  input  logic [9:0]                  DrawX,
  input  logic [9:0]                  DrawY,
  input  logic [NUM_SPRITES-1:0]      sprite_hit,
  input  logic [24*NUM_SPRITES-1:0]   sprite_rgb,
  input  logic                        is_wall,
  input  logic                        is_food,
  input  logic                        frightened,
  input  logic                        fright_ending,
  output logic [7:0]                  VGA_R,
  output logic [7:0]                  VGA_G,
  output logic [7:0]                  VGA_B,
  output logic                        out_valid,
  output logic [7:0]                  o_dbg_blink_cnt,
  output logic                        o_dbg_blink_phase
);

  // Flow: pixel_valid qualifies the inputs of the current cycle; there is no
  // backpressure, so every valid pixel emerges with out_valid two cycles later.

  typedef enum logic {
    PHASE_STEADY = 1'b0,
    PHASE_FLASH  = 1'b1
  } blink_phase_e;

  localparam logic [7:0] BLINK_LAST = 8'(BLINK_FRAMES - 1);

  blink_phase_e r_phase;
  blink_phase_e w_phase_nxt;
  logic [7:0]   r_blink_cnt;
  logic [7:0]   w_blink_cnt_nxt;

  logic         w_in_maze;
  logic [23:0]  w_sel_rgb;
  logic         w_sel_ghost;

  logic         r_s1_valid;
  logic [23:0]  r_s1_rgb;
  logic         r_s1_ghost;
  logic         r_s1_fright;
  logic         r_s1_flash;

  logic [23:0]  w_s2_rgb;
  logic [23:0]  r_out_rgb;
  logic         r_out_valid;

  logic         w_unused_drawx;

  assign w_unused_drawx = ^DrawX;

  // ---------------------------------------------------------------------------
  // Blink state: counts frames while fright_ending is held, toggles the phase
  // every BLINK_FRAMES frames. Dropping fright_ending overrides any frame tick.
  // ---------------------------------------------------------------------------
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_phase     <= PHASE_STEADY;
      r_blink_cnt <= 8'd0;
    end else begin
      r_phase     <= w_phase_nxt;
      r_blink_cnt <= w_blink_cnt_nxt;
    end
  end

  always_comb begin
    w_phase_nxt     = r_phase;
    w_blink_cnt_nxt = r_blink_cnt;
    if (!fright_ending) begin
      w_phase_nxt     = PHASE_STEADY;
      w_blink_cnt_nxt = 8'd0;
    end else if (frame_start) begin
      if (r_blink_cnt == BLINK_LAST) begin
        w_blink_cnt_nxt = 8'd0;
        w_phase_nxt     = (r_phase == PHASE_STEADY) ? PHASE_FLASH : PHASE_STEADY;
      end else begin
        w_blink_cnt_nxt = r_blink_cnt + 8'd1;
      end
    end
  end

  assign o_dbg_blink_cnt   = r_blink_cnt;
  assign o_dbg_blink_phase = (r_phase == PHASE_FLASH);

  // ---------------------------------------------------------------------------
  // Stage 1: layer selection. Later assignments win, so the sprite loop runs
  // from the highest index down to leave the lowest visible sprite on top.
  // ---------------------------------------------------------------------------
  assign w_in_maze = ({22'd0, DrawY} < MAZE_Y_MAX);

  always_comb begin
    w_sel_rgb   = BG_RGB;
    w_sel_ghost = 1'b0;
    if (w_in_maze && is_wall) begin
      w_sel_rgb = WALL_RGB;
    end
    if (w_in_maze && is_food) begin
      w_sel_rgb = FOOD_RGB;
    end
    for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
      if (sprite_hit[i] && (sprite_rgb[24*i +: 24] != KEY_RGB)) begin
        w_sel_rgb   = sprite_rgb[24*i +: 24];
        w_sel_ghost = (i != 0);
      end
    end
  end

  // The flash decision uses the phase held before this edge, so a frame_start
  // only affects pixels presented after it.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_s1_valid  <= 1'b0;
      r_s1_rgb    <= 24'd0;
      r_s1_ghost  <= 1'b0;
      r_s1_fright <= 1'b0;
      r_s1_flash  <= 1'b0;
    end else begin
      r_s1_valid  <= pixel_valid;
      r_s1_rgb    <= w_sel_rgb;
      r_s1_ghost  <= w_sel_ghost;
      r_s1_fright <= frightened;
      r_s1_flash  <= frightened & fright_ending & (r_phase == PHASE_FLASH);
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: ghost recolouring and output blanking.
  // ---------------------------------------------------------------------------
  always_comb begin
    w_s2_rgb = r_s1_rgb;
    if (r_s1_ghost && r_s1_fright) begin
      w_s2_rgb = r_s1_flash ? FLASH_RGB : FRIGHT_RGB;
    end
    if (!r_s1_valid) begin
      w_s2_rgb = 24'd0;
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_out_rgb   <= 24'd0;
      r_out_valid <= 1'b0;
    end else begin
      r_out_rgb   <= w_s2_rgb;
      r_out_valid <= r_s1_valid;
    end
  end

  assign VGA_R     = r_out_rgb[23:16];
  assign VGA_G     = r_out_rgb[15:8];
  assign VGA_B     = r_out_rgb[7:0];
  assign out_valid = r_out_valid;

endmodule

// File: tb/tb_layered_color_mapper.sv
// Directed bench for layered_color_mapper: stimulus pushes expected colours with their
// issue cycle; a negedge monitor pops them when out_valid is seen and checks colour and latency.
module tb_layered_color_mapper;

  logic        Clk = 1'b0;
  logic        Reset = 1'b0;
  logic        pixel_valid = 1'b0;
  logic        frame_start = 1'b0;
  logic [9:0]  DrawX = '0;
  logic [9:0]  DrawY = '0;
  logic [3:0]  sprite_hit = '0;
  logic [95:0] sprite_rgb = '0;
  logic        is_wall = 1'b0;
  logic        is_food = 1'b0;
  logic        frightened = 1'b0;
  logic        fright_ending = 1'b0;
  logic [7:0]  VGA_R, VGA_G, VGA_B;
  logic        out_valid;
  logic [7:0]  o_dbg_blink_cnt;
  logic        o_dbg_blink_phase;

  logic [15:0] cyc = '0;
  logic [39:0] exp_q[$];
  int          n_checks = 0;
  int          n_fail = 0;

  localparam logic [23:0] FRIGHT = 24'h2121FF;
  localparam logic [23:0] FLASH  = 24'hFFFFFF;
  localparam logic [95:0] GHOST1 = {24'h0, 24'h0, 24'hFF0000, 24'h0};

  layered_color_mapper #(
    .NUM_SPRITES (4),
    .BLINK_FRAMES(2)
  ) dut (
    .Clk              (Clk),
    .Reset            (Reset),
    .pixel_valid      (pixel_valid),
    .frame_start      (frame_start),
    .DrawX            (DrawX),
    .DrawY            (DrawY),
    .sprite_hit       (sprite_hit),
    .sprite_rgb       (sprite_rgb),
    .is_wall          (is_wall),
    .is_food          (is_food),
    .frightened       (frightened),
    .fright_ending    (fright_ending),
    .VGA_R            (VGA_R),
    .VGA_G            (VGA_G),
    .VGA_B            (VGA_B),
    .out_valid        (out_valid),
    .o_dbg_blink_cnt  (o_dbg_blink_cnt),
    .o_dbg_blink_phase(o_dbg_blink_phase)
  );

  // Clock and cycle counter
  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 16'd1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  // A pixel presented during cycle n is expected on the outputs during cycle n+2.
  task automatic px(input logic [3:0] hit, input logic [95:0] rgbs, input logic wall,
                    input logic food, input logic [9:0] y, input logic pv, input logic fs,
                    input logic [23:0] exp_rgb);
    @(negedge Clk);
    sprite_hit  = hit;
    sprite_rgb  = rgbs;
    is_wall     = wall;
    is_food     = food;
    DrawY       = y;
    DrawX       = 10'($urandom_range(0, 639));
    pixel_valid = pv;
    frame_start = fs;
    if (pv) exp_q.push_back({cyc, exp_rgb});
    @(posedge Clk);
    #1;
    pixel_valid = 1'b0;
    frame_start = 1'b0;
    sprite_hit  = '0;
  endtask

  task automatic set_mode(input logic fr, input logic fe, input logic fs);
    @(negedge Clk);
    frightened    = fr;
    fright_ending = fe;
    frame_start   = fs;
    @(posedge Clk);
    #1;
    frame_start = 1'b0;
  endtask

  task automatic frame();
    set_mode(frightened, fright_ending, 1'b1);
  endtask

  task automatic check_blink(input string name, input logic [7:0] cnt, input logic phase);
    check({name, "_cnt"}, 32'(o_dbg_blink_cnt), 32'(cnt));
    check({name, "_phase"}, 32'(o_dbg_blink_phase), 32'(phase));
  endtask

  // Scoreboard monitor
  always @(negedge Clk) begin
    logic [39:0] e;
    logic [23:0] got;
    logic [15:0] lat;
    got = {VGA_R, VGA_G, VGA_B};
    if (Reset) begin
      n_checks++;
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_output got=%h exp=no_valid_output", got);
        end else begin
          e   = exp_q.pop_front();
          lat = cyc - e[39:24];
          if (got !== e[23:0] || lat != 16'd2) begin
            n_fail++;
            $display("FAIL pixel_out got=%h latency=%0d exp=%h latency=2", got, lat, e[23:0]);
          end
        end
      end else if (got !== 24'd0) begin
        n_fail++;
        $display("FAIL idle_rgb got=%h exp=000000", got);
      end
    end
  end

  initial begin
    // Reset held across a clock edge
    #12;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_rgb", 32'({VGA_R, VGA_G, VGA_B}), 32'd0);
    check_blink("rst_blink", 8'd0, 1'b0);
    @(negedge Clk);
    Reset = 1'b1;

    // Layer precedence and transparency
    px(4'b0110, {24'h0, 24'h00FF00, 24'h000000, 24'h0}, 0, 0, 10'd10, 1, 0, 24'h00FF00);
    px(4'b0000, 96'd0, 1, 1, 10'd351, 1, 0, 24'hFFFF00);
    px(4'b0000, 96'd0, 1, 1, 10'd352, 1, 0, 24'h3F007F);
    px(4'b0000, 96'd0, 1, 0, 10'd100, 1, 0, 24'hFF0000);
    px(4'b0000, 96'd0, 0, 0, 10'd10, 1, 0, 24'h3F007F);
    px(4'b0000, {72'd0, 24'h777777}, 0, 0, 10'd10, 1, 0, 24'h3F007F);
    px(4'b1111, {24'h445566, 24'h334455, 24'h223344, 24'h112233}, 1, 1, 10'd3, 1, 0, 24'h112233);
    px(4'b1000, {24'hABCDEF, 72'd0}, 0, 1, 10'd20, 1, 0, 24'hABCDEF);
    px(4'b0001, {72'd0, 24'h000001}, 0, 1, 10'd20, 1, 0, 24'h000001);
    px(4'b0001, {72'd0, 24'h010000}, 0, 1, 10'd20, 1, 0, 24'h010000);
    px(4'b0001, 96'd0, 0, 1, 10'd5, 1, 0, 24'hFFFF00);
    px(4'b1001, {24'h0A0B0C, 48'd0, 24'h000000}, 1, 0, 10'd5, 1, 0, 24'h0A0B0C);
    px(4'b0001, {72'd0, 24'h0000FF}, 0, 1, 10'd400, 1, 0, 24'h0000FF);
    px(4'b0001, {72'd0, 24'h123456}, 0, 0, 10'd10, 0, 0, 24'h000000);
    px(4'b0001, {72'd0, 24'h123456}, 0, 0, 10'd10, 0, 0, 24'h000000);

    // Frightened ghosts without blinking
    set_mode(1, 0, 0);
    px(4'b0010, GHOST1, 0, 0, 10'd10, 1, 0, FRIGHT);
    px(4'b0001, {72'd0, 24'hFF0000}, 0, 0, 10'd10, 1, 0, 24'hFF0000);
    px(4'b0000, 96'd0, 0, 1, 10'd10, 1, 0, 24'hFFFF00);

    // Blinking with a two-frame half period
    set_mode(1, 1, 0);
    check_blink("blink_start", 8'd0, 1'b0);
    px(4'b0010, GHOST1, 0, 0, 10'd10, 1, 0, FRIGHT);
    frame();
    check_blink("blink_f1", 8'd1, 1'b0);
    px(4'b0010, GHOST1, 0, 0, 10'd10, 1, 0, FRIGHT);
    frame();
    check_blink("blink_f2", 8'd0, 1'b1);
    px(4'b0010, GHOST1, 0, 0, 10'd10, 1, 0, FLASH);
    frame();
    px(4'b0010, GHOST1, 0, 0, 10'd10, 1, 1, FLASH);
    check_blink("blink_f4", 8'd0, 1'b0);
    px(4'b0010, GHOST1, 0, 0, 10'd10, 1, 0, FRIGHT);
    frame();
    frame();
    check_blink("blink_f6", 8'd0, 1'b1);
    px(4'b0010, GHOST1, 0, 0, 10'd10, 1, 0, FLASH);
    set_mode(1, 0, 1);
    check_blink("blink_drop", 8'd0, 1'b0);
    px(4'b0010, GHOST1, 0, 0, 10'd10, 1, 0, FRIGHT);

    // fright_ending alone: counter runs, colours untouched
    set_mode(0, 1, 0);
    px(4'b0010, GHOST1, 0, 0, 10'd10, 1, 0, 24'hFF0000);
    frame();
    frame();
    check_blink("nofright_run", 8'd0, 1'b1);
    px(4'b0010, GHOST1, 0, 0, 10'd10, 1, 0, 24'hFF0000);
    set_mode(0, 0, 0);
    check_blink("nofright_clear", 8'd0, 1'b0);

    // Asynchronous reset in the middle of a stream
    px(4'b0001, {72'd0, 24'h010203}, 0, 0, 10'd10, 1, 0, 24'h010203);
    px(4'b0000, 96'd0, 0, 1, 10'd0, 1, 0, 24'hFFFF00);
    px(4'b0000, 96'd0, 1, 0, 10'd1, 1, 0, 24'hFF0000);
    #1;
    Reset = 1'b0;
    #1;
    check("async_rst_valid", 32'(out_valid), 32'd0);
    check("async_rst_rgb", 32'({VGA_R, VGA_G, VGA_B}), 32'd0);
    exp_q.delete();
    repeat (3) @(negedge Clk);
    check("rst_hold_valid", 32'(out_valid), 32'd0);
    Reset = 1'b1;
    px(4'b0000, 96'd0, 0, 0, 10'd10, 0, 0, 24'h000000);
    px(4'b0000, 96'd0, 0, 0, 10'd10, 0, 0, 24'h000000);
    px(4'b0100, {24'h0, 24'h00AA55, 48'd0}, 0, 0, 10'd10, 1, 0, 24'h00AA55);
    px(4'b0000, 96'd0, 1, 0, 10'd10, 1, 0, 24'hFF0000);

    // Bounded drain of the scoreboard
    repeat (6) @(negedge Clk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
